multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle control FSM that sequences fetch, decode, execute, memory and writeback around the 32-bit instruction format.
- Instruction fields: opcode [31:28], fn [3:0], reg1 [27:23], reg2 [22:18], shamt [17:12], imm [22:7].
- Consumes opcode/fn from the decode stage, plus memory handshakes and the ALU zero flag.
- Drives all datapath enables and selects: IR, PC, register file, ALU, data memory.

Parameters:
- TMO_W, 4, width of the memory-wait timeout counter.
- MEM_TIMEOUT, 15, maximum MEM-state wait cycles before abort; must be ≤ 2^TMO_W-1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  decoded instr[31:28]; valid from DECODE onward.
- fncode  in  4  decoded instr[3:0].
- imem_ready  in  1  instruction-memory data valid; sampled only while imem_req=1.
- dmem_ready  in  1  data-memory access complete; sampled only while dmem_req=1.
- alu_zero  in  1  ALU result==0; sampled in EXECUTE.
- resume  in  1  leave HALT.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC.
- pc_src  out  2  0=PC+4, 1=PC+imm (branch), 2=imm (jump).
- alu_op  out  4  ALU function.
- alu_src  out  2  B operand: 0=reg2, 1=imm, 2=shamt.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  data-memory write (store).
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback source: 1=memory, 0=ALU.
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- mem_err  out  1  one-cycle pulse on memory timeout.
- halted  out  1  high in HALT.
- state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5.
- instr_count  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Opcode map:
  - 0: ALU reg-reg
  - 1: ALU immediate
  - 2: shift by shamt
  - 3: LOAD
  - 4: STORE
  - 5: BZ (branch if zero)
  - 6: BNZ (branch if not zero)
  - 7: JUMP
  - F: HALT
  - 8–E: illegal
- Reset: while rst=1, state→FETCH, op_q/fn_q/timeout counter→0, and every output is 0. The rst clause has priority over all other events.
- Outputs are decoded combinationally from state plus op_q/fn_q. op_q/fn_q are latched from opcode/fncode on the DECODE cycle.
- FETCH:
  - imem_req=1 until imem_ready.
  - In the imem_ready cycle: ir_write=1, pc_write=1, pc_src=0; next state DECODE.
  - Without imem_ready: remain in FETCH.
- DECODE (1 cycle):
  - Latch op_q/fn_q.
  - HALT opcode → HALT.
  - Illegal opcode → FETCH, with illegal_op=1 during this cycle.
  - Otherwise → EXECUTE.
- EXECUTE (1 cycle): alu_op and alu_src by opcode:
  - op 0: alu_op=fn_q, alu_src=0
  - op 1: alu_op=0 (ADD), alu_src=1
  - op 2: alu_op=fn_q, alu_src=2
  - op 3/4: alu_op=0 (ADD), alu_src=1
  - op 5/6: alu_op=1 (SUB), alu_src=0
- EXECUTE next state:
  - ALU/shift ops → WB.
  - LOAD/STORE → MEM.
  - Branch taken (BZ with alu_zero=1, or BNZ with alu_zero=0): pc_write=1, pc_src=1.
  - JUMP: pc_write=1, pc_src=2.
  - Branch (taken or not) and JUMP → FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE; alu_src=1 and alu_op=0 held.
  - Timeout counter starts at 0 on entry and increments each cycle without dmem_ready.
  - On dmem_ready: LOAD→WB, STORE→FETCH.
  - If counter==MEM_TIMEOUT with dmem_ready=0: mem_err=1 for this cycle, no WB, → FETCH.
  - dmem_ready on the same cycle the counter hits the limit counts as success.
- WB (1 cycle): reg_write=1; mem_to_reg=1 for LOAD, 0 otherwise; → FETCH.
- HALT:
  - halted=1; all enables 0.
  - resume=1 → FETCH on the next edge.
  - resume outside HALT is ignored.
- Timing:
  - Latencies excluding memory waits: ALU/shift 4 cycles, LOAD 5, STORE 4, branch/jump 3.
  - imem_ready/dmem_ready asserted outside their request windows are ignored.
- Reset during MEM or FETCH abandons the access; requests drop in the same cycle rst is sampled.

Optional Feature:
- Macro: PERF_COUNT_EN.
- Defined:
  - instr_count is a 32-bit register, reset to 0.
  - Increments by 1 on each retirement: exit of WB, STORE success, and EXECUTE for branch/jump.
  - No increment for illegal ops, timeouts or HALT.
  - Wraps from FFFFFFFF to 0.
- Undefined: instr_count is tied to 0 and no counter logic exists.

Test Plan:
- ALU op=0, fn=3, imem_ready on first FETCH cycle → states 0,1,2,4,0; alu_op=3 and alu_src=0 in EXECUTE; reg_write=1 exactly one cycle; instr_count=1 (PERF_COUNT_EN).
- LOAD op=3, dmem_ready after 3 wait cycles → dmem_req high 4 cycles, dmem_we=0, then WB with mem_to_reg=1 and reg_write=1.
- STORE op=4, dmem_ready never asserted, MEM_TIMEOUT=15 → mem_err pulses on the 16th MEM cycle, next state FETCH, reg_write never 1, instr_count unchanged.
- BZ op=5:
  - alu_zero=1 → pc_write=1, pc_src=1 in EXECUTE.
  - Repeat with alu_zero=0 → no EXECUTE pc_write.
  - Both cases → FETCH.
- Opcode 9 → illegal_op=1 for one cycle in DECODE, then FETCH. Opcode F → halted=1 held for 10 cycles; resume pulse → state 0 next cycle.
- rst=1 asserted mid-MEM with dmem_req=1 → on that edge state=0 and all outputs 0; after release, imem_req=1 on the first cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM sequencing FETCH/DECODE/EXECUTE/MEM/WB/HALT, with a data-memory wait timeout.
// Define PERF_COUNT_EN to build the retired-instruction counter; otherwise instr_count is tied to 0.
module multicycle_control #(
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic [3:0]  fncode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  input  logic        resume,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_src,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal_op,
  output logic        mem_err,
  output logic        halted,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_ALU   = 4'h0;
  localparam logic [3:0] OP_ALUI  = 4'h1;
  localparam logic [3:0] OP_SHIFT = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_BZ    = 4'h5;
  localparam logic [3:0] OP_BNZ   = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_op_q;
  logic [3:0]       r_fn_q;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_tmo_hit;
  logic             w_branch_taken;

  // A ready arriving on the limit cycle is a success, so only a silent limit cycle aborts.
  assign w_tmo_hit      = (r_tmo_cnt == TMO_LIMIT) && !dmem_ready;
  assign w_branch_taken = ((r_op_q == OP_BZ) && alu_zero) || ((r_op_q == OP_BNZ) && !alu_zero);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_op_q    <= '0;
      r_fn_q    <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_op_q <= opcode;
        r_fn_q <= fncode;
      end
      if (r_state != S_MEM) begin
        r_tmo_cnt <= '0;
      end else if (!dmem_ready && (r_tmo_cnt != TMO_LIMIT)) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    w_next_state = r_state;
    case (r_state)
      S_FETCH:   if (imem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_HALT: w_next_state = S_HALT;
          OP_ALU, OP_ALUI, OP_SHIFT, OP_LOAD, OP_STORE, OP_BZ, OP_BNZ, OP_JUMP:
                   w_next_state = S_EXECUTE;
          default: w_next_state = S_FETCH;
        endcase
      end
      S_EXECUTE: begin
        case (r_op_q)
          OP_ALU, OP_ALUI, OP_SHIFT: w_next_state = S_WB;
          OP_LOAD, OP_STORE:         w_next_state = S_MEM;
          default:                   w_next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_ready)     w_next_state = (r_op_q == OP_LOAD) ? S_WB : S_FETCH;
        else if (w_tmo_hit) w_next_state = S_FETCH;
      end
      S_WB:      w_next_state = S_FETCH;
      S_HALT:    if (resume) w_next_state = S_FETCH;
      default:   w_next_state = S_FETCH;
    endcase
  end

  // Outputs are forced low while rst is high so in-flight requests drop in the reset cycle itself.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_op     = 4'd0;
    alu_src    = 2'd0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    halted     = 1'b0;
    state      = 3'd0;
    if (!rst) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
        S_DECODE:  illegal_op = (opcode >= 4'h8) && (opcode <= 4'hE);
        S_EXECUTE: begin
          case (r_op_q)
            OP_ALU:            alu_op  = r_fn_q;
            OP_ALUI:           alu_src = 2'd1;
            OP_SHIFT: begin
              alu_op  = r_fn_q;
              alu_src = 2'd2;
            end
            OP_LOAD, OP_STORE: alu_src = 2'd1;
            OP_BZ, OP_BNZ: begin
              alu_op = 4'd1;
              if (w_branch_taken) begin
                pc_write = 1'b1;
                pc_src   = 2'd1;
              end
            end
            OP_JUMP: begin
              pc_write = 1'b1;
              pc_src   = 2'd2;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (r_op_q == OP_STORE);
          alu_src  = 2'd1;
          mem_err  = w_tmo_hit;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (r_op_q == OP_LOAD);
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PERF_COUNT_EN
  logic [31:0] r_instr_count;
  logic        w_retire;

  // Retirement points: WB exit, successful STORE, and any branch/jump leaving EXECUTE.
  assign w_retire = (r_state == S_WB)
                 || ((r_state == S_MEM) && (r_op_q == OP_STORE) && dmem_ready)
                 || ((r_state == S_EXECUTE) && ((r_op_q == OP_BZ) || (r_op_q == OP_BNZ) || (r_op_q == OP_JUMP)));

  always_ff @(posedge clk) begin
    if (rst)           r_instr_count <= '0;
    else if (w_retire) r_instr_count <= r_instr_count + 32'd1;
  end

  assign instr_count = rst ? 32'd0 : r_instr_count;
`else
  assign instr_count = 32'd0;
`endif

endmodule
